// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command decoder:
//   - ASCII byte values recognised on the UART path
//   - cmd_t         : decoded command (one value per output pulse)
//   - rep_state_t   : auto-repeat FSM states
//   - button index constants for the packed button vector
//   - decode_ascii / is_ignored helper functions
// -----------------------------------------------------------------------------
package cmd_pkg;

    // ASCII command characters, upper and lower case
    localparam logic [7:0] ASCII_UP_UC    = 8'h55; // 'U'
    localparam logic [7:0] ASCII_UP_LC    = 8'h75; // 'u'
    localparam logic [7:0] ASCII_DOWN_UC  = 8'h44; // 'D'
    localparam logic [7:0] ASCII_DOWN_LC  = 8'h64; // 'd'
    localparam logic [7:0] ASCII_LEFT_UC  = 8'h4C; // 'L'
    localparam logic [7:0] ASCII_LEFT_LC  = 8'h6C; // 'l'
    localparam logic [7:0] ASCII_RIGHT_UC = 8'h52; // 'R'
    localparam logic [7:0] ASCII_RIGHT_LC = 8'h72; // 'r'
    localparam logic [7:0] ASCII_CLEAR_UC = 8'h43; // 'C'
    localparam logic [7:0] ASCII_CLEAR_LC = 8'h63; // 'c'
    localparam logic [7:0] ASCII_MODE_UC  = 8'h4D; // 'M'
    localparam logic [7:0] ASCII_MODE_LC  = 8'h6D; // 'm'
    // Line terminators sent by terminals; silently discarded
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;

    // Bit positions inside the packed button vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_CLEAR = 4;
    localparam int NUM_BTN   = 5;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_CLEAR = 3'd5,
        CMD_MODE  = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_t;

    // Map a received byte to a command; CMD_NONE for anything unrecognised
    function automatic cmd_t decode_ascii(input logic [7:0] b);
        cmd_t result;
        case (b)
            ASCII_UP_UC,    ASCII_UP_LC:    result = CMD_UP;
            ASCII_DOWN_UC,  ASCII_DOWN_LC:  result = CMD_DOWN;
            ASCII_LEFT_UC,  ASCII_LEFT_LC:  result = CMD_LEFT;
            ASCII_RIGHT_UC, ASCII_RIGHT_LC: result = CMD_RIGHT;
            ASCII_CLEAR_UC, ASCII_CLEAR_LC: result = CMD_CLEAR;
            ASCII_MODE_UC,  ASCII_MODE_LC:  result = CMD_MODE;
            default:                        result = CMD_NONE;
        endcase
        return result;
    endfunction

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// -----------------------------------------------------------------------------
// key_repeat_timer
// Auto-repeat FSM for the up/down buttons. Arms on an up or down edge while
// the opposite button is released, waits REPEAT_DELAY_CYC cycles, then fires
// every REPEAT_RATE_CYC cycles for as long as the same button alone is held.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   up_level, down_level  : registered button levels
//   up_edge, down_edge    : rising-edge flags aligned with the levels above
//   rep_up, rep_down      : combinational fire flags for this cycle
// -----------------------------------------------------------------------------
module key_repeat_timer #(
    parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic up_level,
    input  logic down_level,
    input  logic up_edge,
    input  logic down_edge,
    output logic rep_up,
    output logic rep_down
);
    import cmd_pkg::*;

    localparam int unsigned MAX_CYC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYC - 1);

    rep_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_up_reg, dir_up_next;
    logic             held;
    logic             fire;

    // Only the armed button held on its own keeps the sequence alive;
    // pressing both at once cancels it.
    assign held = dir_up_reg ? (up_level & ~down_level) : (down_level & ~up_level);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dir_up_next = dir_up_reg;
        fire        = 1'b0;
        case (state_reg)
            R_IDLE: begin
                cnt_next = '0;
                if (up_edge && !down_level) begin
                    state_next  = R_DELAY;
                    dir_up_next = 1'b1;
                end else if (down_edge && !up_level) begin
                    state_next  = R_DELAY;
                    dir_up_next = 1'b0;
                end
            end
            R_DELAY: begin
                if (!held) begin
                    state_next = R_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DELAY_LAST) begin
                    fire       = 1'b1;
                    state_next = R_REPEAT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            R_REPEAT: begin
                if (!held) begin
                    state_next = R_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == RATE_LAST) begin
                    fire     = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = R_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= R_IDLE;
            cnt_reg    <= '0;
            dir_up_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dir_up_reg <= dir_up_next;
        end
    end

    assign rep_up   = fire & dir_up_reg;
    assign rep_down = fire & ~dir_up_reg;

endmodule

// File: rtl/command_decoder.sv
// -----------------------------------------------------------------------------
// command_decoder
// Merges debounced buttons and UART command bytes into one-cycle, mutually
// exclusive command pulses. Priority each cycle: button edge, then up/down
// auto-repeat, then the single pending UART command.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   rx_data, rx_done           : received byte and its one-cycle strobe
//   btn_up/down/left/right/clear : debounced levels, 1 = pressed
//   up/down/left/right/clear_pulse, mode_toggle_pulse : registered pulses
//   cmd_error                  : unknown byte or byte dropped (pending busy)
// -----------------------------------------------------------------------------
module command_decoder #(
    parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_clear,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       clear_pulse,
    output logic       mode_toggle_pulse,
    output logic       cmd_error
);
    import cmd_pkg::*;

    logic [NUM_BTN-1:0] btn_now;
    logic [NUM_BTN-1:0] btn_reg;
    logic [NUM_BTN-1:0] btn_prev_reg;
    logic [NUM_BTN-1:0] btn_edge;

    logic rep_up, rep_down;
    logic btn_hit, rep_hit;
    logic emit_pending;

    cmd_t sel_cmd;
    cmd_t rx_cmd;
    logic rx_ignore;

    logic pend_valid_reg, pend_valid_next;
    cmd_t pend_cmd_reg,   pend_cmd_next;
    logic err_reg,        err_next;

    assign btn_now = {btn_clear, btn_right, btn_left, btn_down, btn_up};

    // Two-stage sampling: the edge is seen one cycle after the level is
    // sampled, so every pulse lands on the edge after the sampling edge.
    // Reset loads both stages with the live level, so a button held through
    // reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_reg      <= btn_now;
            btn_prev_reg <= btn_now;
        end else begin
            btn_reg      <= btn_now;
            btn_prev_reg <= btn_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
            assign btn_edge[gi] = btn_reg[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    key_repeat_timer #(
        .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
        .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
    ) u_key_repeat_timer (
        .clk        (clk),
        .reset      (reset),
        .up_level   (btn_reg[BTN_UP]),
        .down_level (btn_reg[BTN_DOWN]),
        .up_edge    (btn_edge[BTN_UP]),
        .down_edge  (btn_edge[BTN_DOWN]),
        .rep_up     (rep_up),
        .rep_down   (rep_down)
    );

    assign btn_hit      = |btn_edge;
    assign rep_hit      = rep_up | rep_down;
    assign emit_pending = pend_valid_reg & ~btn_hit & ~rep_hit;

    assign rx_cmd    = decode_ascii(rx_data);
    assign rx_ignore = is_ignored(rx_data);

    // Output selection: simultaneous button edges lose silently to the
    // higher-priority one; the pending command just waits its turn.
    always_comb begin
        sel_cmd = CMD_NONE;
        if (btn_edge[BTN_CLEAR])      sel_cmd = CMD_CLEAR;
        else if (btn_edge[BTN_UP])    sel_cmd = CMD_UP;
        else if (btn_edge[BTN_DOWN])  sel_cmd = CMD_DOWN;
        else if (btn_edge[BTN_LEFT])  sel_cmd = CMD_LEFT;
        else if (btn_edge[BTN_RIGHT]) sel_cmd = CMD_RIGHT;
        else if (rep_up)              sel_cmd = CMD_UP;
        else if (rep_down)            sel_cmd = CMD_DOWN;
        else if (pend_valid_reg)      sel_cmd = pend_cmd_reg;
    end

    // Pending slot: a new byte may replace the entry that is leaving this
    // very cycle; otherwise a full slot keeps its entry and the byte is lost.
    always_comb begin
        pend_valid_next = pend_valid_reg;
        pend_cmd_next   = pend_cmd_reg;
        err_next        = 1'b0;
        if (emit_pending) begin
            pend_valid_next = 1'b0;
        end
        if (rx_done) begin
            if (rx_cmd != CMD_NONE) begin
                if (!pend_valid_reg || emit_pending) begin
                    pend_valid_next = 1'b1;
                    pend_cmd_next   = rx_cmd;
                end else begin
                    err_next = 1'b1;
                end
            end else if (!rx_ignore) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_pulse          <= 1'b0;
            down_pulse        <= 1'b0;
            left_pulse        <= 1'b0;
            right_pulse       <= 1'b0;
            clear_pulse       <= 1'b0;
            mode_toggle_pulse <= 1'b0;
            cmd_error         <= 1'b0;
            err_reg           <= 1'b0;
            pend_valid_reg    <= 1'b0;
            pend_cmd_reg      <= CMD_NONE;
        end else begin
            up_pulse          <= (sel_cmd == CMD_UP);
            down_pulse        <= (sel_cmd == CMD_DOWN);
            left_pulse        <= (sel_cmd == CMD_LEFT);
            right_pulse       <= (sel_cmd == CMD_RIGHT);
            clear_pulse       <= (sel_cmd == CMD_CLEAR);
            mode_toggle_pulse <= (sel_cmd == CMD_MODE);
            // Error is flagged at the byte's sampling edge and reported one
            // edge later, matching the latency of a decoded command.
            err_reg           <= err_next;
            cmd_error         <= err_reg;
            pend_valid_reg    <= pend_valid_next;
            pend_cmd_reg      <= pend_cmd_next;
        end
    end

endmodule
